dbus_uart: RTL



---
 rtl/dbus_uart_pkg.sv | 24 ++
 rtl/dbus_uart_fifo.sv | 61 ++++++
 rtl/dbus_uart.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dbus_uart_pkg.sv
// Shared definitions for the data-bus UART: register offsets, STATUS bit
// positions, serializer state encoding and the default baud divisor.
package dbus_uart_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam logic [15:0] UART_DEFAULT_DIV = 16'd433;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/dbus_uart_fifo.sv
// Synchronous byte FIFO feeding the UART serializer; head is visible
// combinationally so the serializer can load it on the popping edge.
module uart_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dbus_uart.sv
// Memory-mapped 8N1 UART transmitter on the cpu data bus: DATA/STATUS/DIV
// registers, a TX FIFO and a serializer with a programmable baud divisor.
module dbus_uart
  import dbus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hF000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dbus_addr,
  input  logic [31:0] dbus_write,
  input  logic        dbus_wen,
  output logic [31:0] dbus_read,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [1:0]    offset;
  logic          wr_data, wr_status, wr_div;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          bit_end, busy;

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] per_div_q, per_div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  logic unused_bits;
  assign unused_bits = ^{dbus_addr[1:0], dbus_write[31:16], fifo_count};

  assign hit       = dbus_addr[15:4] == BASE_ADDR[15:4];
  assign offset    = dbus_addr[3:2];
  assign wr_data   = dbus_wen && hit && (offset == OFF_DATA);
  assign wr_status = dbus_wen && hit && (offset == OFF_STATUS);
  assign wr_div    = dbus_wen && hit && (offset == OFF_DIV);
  assign busy      = state_q != S_IDLE;
  assign tx        = tx_q;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_data),
    .push_data (dbus_write[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // per_div_q holds the divisor latched at the start of the current bit, so
  // a DIV write only affects the period that begins after it.
  assign bit_end = baud_q == per_div_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    per_div_d = per_div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    if (state_q != S_IDLE) begin
      if (bit_end) begin
        baud_d    = '0;
        per_div_d = div_q;
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          tx_d      = 1'b0;
          baud_d    = '0;
          per_div_d = div_q;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div) div_d = dbus_write[15:0];
    if (wr_status) ovf_d = 1'b0;
    else if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_comb begin
    dbus_read = '0;
    if (hit) begin
      case (offset)
        OFF_STATUS: begin
          dbus_read[ST_FULL]  = fifo_full;
          dbus_read[ST_EMPTY] = fifo_empty;
          dbus_read[ST_BUSY]  = busy;
          dbus_read[ST_OVF]   = ovf_q;
        end
        OFF_DIV: dbus_read[15:0] = div_q;
        default: dbus_read = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      per_div_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      per_div_q <= per_div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
